// File: rtl/mastermind_game_ctrl.sv
// Mastermind game controller: latches the secret code, accepts one guess at a time,
// scores it serially (exact pegs, then per-colour minimum counts) and tracks turns/win.
module mastermind_game_ctrl #(
   parameter int unsigned PEGS      = 4,
   parameter int unsigned CW        = 3,
   parameter int unsigned MAX_TURNS = 8,
   parameter int unsigned CNTW      = $clog2(PEGS + 1),
   parameter int unsigned TW        = $clog2(MAX_TURNS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PEGS*CW-1:0]   code_in,
   input  logic                 guess_valid,
   input  logic [PEGS*CW-1:0]   guess_in,
   output logic                 guess_ready,
   output logic                 score_valid,
   output logic [CNTW-1:0]      exact,
   output logic [CNTW-1:0]      partial,
   output logic [TW-1:0]        turn,
   output logic                 win,
   output logic                 game_over
);

   localparam int unsigned NCOL = 2 ** CW;
   localparam int unsigned IW   = (PEGS > 1) ? $clog2(PEGS) : 1;
   localparam int unsigned DW   = PEGS * CW;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLAY   = 3'd1,
      S_EXACT  = 3'd2,
      S_COLOR  = 3'd3,
      S_REPORT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     code_q, code_d;
   logic [DW-1:0]     guess_q, guess_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     col_q, col_d;
   logic [CNTW-1:0]   ex_acc_q, ex_acc_d;
   logic [CNTW-1:0]   m_acc_q, m_acc_d;
   logic [CNTW-1:0]   exact_q, exact_d;
   logic [CNTW-1:0]   partial_q, partial_d;
   logic [TW-1:0]     turn_q, turn_d;
   logic              win_q, win_d;
   logic              score_valid_q, score_valid_d;
   logic              guess_ready_q, guess_ready_d;
   logic              game_over_q, game_over_d;

   logic              hit_c;
   logic [CNTW-1:0]   cc_c, gc_c, min_c, m_fin_c;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         code_q        <= '0;
         guess_q       <= '0;
         idx_q         <= '0;
         col_q         <= '0;
         ex_acc_q      <= '0;
         m_acc_q       <= '0;
         exact_q       <= '0;
         partial_q     <= '0;
         turn_q        <= '0;
         win_q         <= 1'b0;
         score_valid_q <= 1'b0;
         guess_ready_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         code_q        <= code_d;
         guess_q       <= guess_d;
         idx_q         <= idx_d;
         col_q         <= col_d;
         ex_acc_q      <= ex_acc_d;
         m_acc_q       <= m_acc_d;
         exact_q       <= exact_d;
         partial_q     <= partial_d;
         turn_q        <= turn_d;
         win_q         <= win_d;
         score_valid_q <= score_valid_d;
         guess_ready_q <= guess_ready_d;
         game_over_q   <= game_over_d;
      end
   end

   // Per-peg exact hit at idx_q and per-colour occurrence counts at col_q
   always_comb begin
      hit_c = 1'b0;
      cc_c  = '0;
      gc_c  = '0;
      for (int i = 0; i < PEGS; i++) begin
         if (IW'(i) == idx_q) hit_c = (guess_q[i*CW +: CW] == code_q[i*CW +: CW]);
         if (code_q[i*CW +: CW] == col_q)  cc_c = cc_c + CNTW'(1);
         if (guess_q[i*CW +: CW] == col_q) gc_c = gc_c + CNTW'(1);
      end
      min_c   = (cc_c < gc_c) ? cc_c : gc_c;
      m_fin_c = m_acc_q + min_c;
   end

   // Next-state logic; start overrides everything, including a same-cycle handshake
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_PLAY;
      end else begin
         unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_PLAY:   if (guess_valid) state_d = S_EXACT;
            S_EXACT:  if (idx_q == IW'(PEGS - 1)) state_d = S_COLOR;
            S_COLOR:  if (col_q == CW'(NCOL - 1)) state_d = S_REPORT;
            S_REPORT: begin
               if (win_q || (turn_q == TW'(MAX_TURNS))) state_d = S_DONE;
               else                                     state_d = S_PLAY;
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Datapath and output updates; the score is registered on the last colour cycle so
   // exact/partial/turn/win are already valid while score_valid is high (REPORT)
   always_comb begin
      code_d        = code_q;
      guess_d       = guess_q;
      idx_d         = idx_q;
      col_d         = col_q;
      ex_acc_d      = ex_acc_q;
      m_acc_d       = m_acc_q;
      exact_d       = exact_q;
      partial_d     = partial_q;
      turn_d        = turn_q;
      win_d         = win_q;
      score_valid_d = 1'b0;
      if (start) begin
         code_d    = code_in;
         idx_d     = '0;
         col_d     = '0;
         ex_acc_d  = '0;
         m_acc_d   = '0;
         exact_d   = '0;
         partial_d = '0;
         turn_d    = '0;
         win_d     = 1'b0;
      end else begin
         unique case (state_q)
            S_PLAY: begin
               if (guess_valid) begin
                  guess_d  = guess_in;
                  idx_d    = '0;
                  col_d    = '0;
                  ex_acc_d = '0;
                  m_acc_d  = '0;
               end
            end
            S_EXACT: begin
               ex_acc_d = ex_acc_q + CNTW'(hit_c);
               idx_d    = (idx_q == IW'(PEGS - 1)) ? '0 : idx_q + IW'(1);
            end
            S_COLOR: begin
               m_acc_d = m_fin_c;
               col_d   = col_q + CW'(1);
               if (col_q == CW'(NCOL - 1)) begin
                  score_valid_d = 1'b1;
                  exact_d       = ex_acc_q;
                  partial_d     = m_fin_c - ex_acc_q;
                  turn_d        = turn_q + TW'(1);
                  win_d         = (ex_acc_q == CNTW'(PEGS));
               end
            end
            default: ;
         endcase
      end
      guess_ready_d = (state_d == S_PLAY);
      game_over_d   = (state_d == S_DONE);
   end

   assign guess_ready = guess_ready_q;
   assign score_valid = score_valid_q;
   assign exact       = exact_q;
   assign partial     = partial_q;
   assign turn        = turn_q;
   assign win         = win_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl against a colour-histogram scoring model.
module tb_mastermind_game_ctrl;
   localparam int PEGS = 4;
   localparam int CW   = 3;
   localparam int NCOL = 8;
   localparam int MT   = 8;
   localparam int CNTW = 3;
   localparam int TW   = 4;
   localparam int W    = PEGS * CW;
   localparam int LAT  = PEGS + NCOL;

   logic            clk = 1'b0;
   logic            rst, start, guess_valid;
   logic [W-1:0]    code_in, guess_in;
   logic            guess_ready, score_valid, win, game_over;
   logic [CNTW-1:0] exact, partial;
   logic [TW-1:0]   turn;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] m_code;
   int           m_turn;
   bit           m_win, m_over;

   mastermind_game_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .code_in(code_in),
      .guess_valid(guess_valid), .guess_in(guess_in), .guess_ready(guess_ready),
      .score_valid(score_valid), .exact(exact), .partial(partial), .turn(turn),
      .win(win), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pk(input int p0, input int p1, input int p2, input int p3);
      logic [W-1:0] r;
      r = '0;
      r[0*CW +: CW] = p0[CW-1:0];
      r[1*CW +: CW] = p1[CW-1:0];
      r[2*CW +: CW] = p2[CW-1:0];
      r[3*CW +: CW] = p3[CW-1:0];
      return r;
   endfunction

   // Classic Mastermind scoring from colour histograms
   function automatic void model(input logic [W-1:0] c, input logic [W-1:0] g,
                                 output int ex, output int pa);
      int cc[NCOL];
      int gc[NCOL];
      int m;
      for (int k = 0; k < NCOL; k++) begin cc[k] = 0; gc[k] = 0; end
      ex = 0;
      m  = 0;
      for (int i = 0; i < PEGS; i++) begin
         int ci, gi;
         ci = int'(c[i*CW +: CW]);
         gi = int'(g[i*CW +: CW]);
         if (ci == gi) ex++;
         cc[ci]++;
         gc[gi]++;
      end
      for (int k = 0; k < NCOL; k++) m += (cc[k] < gc[k]) ? cc[k] : gc[k];
      pa = m - ex;
   endfunction

   task automatic do_start(input logic [W-1:0] c);
      start   = 1'b1;
      code_in = c;
      step();
      start  = 1'b0;
      m_code = c;
      m_turn = 0;
      m_win  = 1'b0;
      m_over = 1'b0;
   endtask

   // Submits one guess, then checks latency, score, turn/win and the following cycle
   task automatic play_guess(input string nm, input logic [W-1:0] g);
      int ex, pa, n, lat;
      model(m_code, g, ex, pa);
      m_turn++;
      m_win  = (ex == PEGS);
      m_over = m_win || (m_turn == MT);
      guess_valid = 1'b1;
      guess_in    = g;
      n = 0;
      while (!guess_ready && n < 20) begin step(); n++; end
      step();
      guess_valid = 1'b0;
      lat = 0;
      while (!score_valid && lat < 40) begin step(); lat++; end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, LAT); end
      checks++;
      if (exact !== CNTW'(ex)) begin errors++; $display("FAIL %s exact: got %0d expected %0d", nm, exact, ex); end
      checks++;
      if (partial !== CNTW'(pa)) begin errors++; $display("FAIL %s partial: got %0d expected %0d", nm, partial, pa); end
      checks++;
      if (turn !== TW'(m_turn)) begin errors++; $display("FAIL %s turn: got %0d expected %0d", nm, turn, m_turn); end
      checks++;
      if (win !== m_win) begin errors++; $display("FAIL %s win: got %0b expected %0b", nm, win, m_win); end
      step();
      checks++;
      if (score_valid !== 1'b0) begin errors++; $display("FAIL %s pulse width: score_valid got %0b expected 0", nm, score_valid); end
      checks++;
      if (game_over !== m_over) begin errors++; $display("FAIL %s game_over: got %0b expected %0b", nm, game_over, m_over); end
      checks++;
      if (guess_ready !== !m_over) begin errors++; $display("FAIL %s guess_ready: got %0b expected %0b", nm, guess_ready, !m_over); end
   endtask

   // Holds guess_valid for a while and expects no score and held outputs
   task automatic expect_ignored(input string nm, input logic [W-1:0] g);
      int pulses;
      logic [CNTW-1:0] ex0, pa0;
      logic [TW-1:0]   t0;
      ex0 = exact; pa0 = partial; t0 = turn;
      pulses = 0;
      guess_valid = 1'b1;
      guess_in    = g;
      for (int i = 0; i < 2 * LAT; i++) begin step(); if (score_valid) pulses++; end
      guess_valid = 1'b0;
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL %s score pulses: got %0d expected 0", nm, pulses); end
      checks++;
      if ({exact, partial, turn} !== {ex0, pa0, t0}) begin
         errors++;
         $display("FAIL %s hold: got e=%0d p=%0d t=%0d expected e=%0d p=%0d t=%0d", nm, exact, partial, turn, ex0, pa0, t0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; guess_valid = 1'b0; code_in = '0; guess_in = '0;
      step(); step();
      checks++;
      if ({guess_ready, score_valid, exact, partial, turn, win, game_over} !== '0) begin
         errors++;
         $display("FAIL reset outputs: got rdy=%0b sv=%0b e=%0d p=%0d t=%0d w=%0b go=%0b expected all 0",
                  guess_ready, score_valid, exact, partial, turn, win, game_over);
      end
      rst = 1'b0;
      step();
      checks++;
      if (guess_ready !== 1'b0) begin errors++; $display("FAIL idle ready: got %0b expected 0", guess_ready); end
   endtask

   task automatic test_basic();
      do_start(pk(1, 2, 3, 4));
      play_guess("basic", pk(4, 3, 2, 1));
   endtask

   task automatic test_duplicates();
      do_start(pk(1, 1, 2, 2));
      play_guess("dup_a", pk(1, 2, 1, 1));
      do_start(pk(5, 5, 5, 5));
      play_guess("dup_b", pk(5, 0, 0, 0));
   endtask

   task automatic test_random();
      for (int gm = 0; gm < 4; gm++) begin
         do_start(W'($urandom));
         for (int k = 0; k < 3; k++) begin
            logic [W-1:0] g;
            g = W'($urandom);
            if ($urandom_range(0, 3) == 0) g[CW-1:0] = m_code[CW-1:0];
            play_guess("random", g);
            if (m_over) break;
         end
      end
   endtask

   task automatic test_win();
      do_start(pk(6, 0, 7, 3));
      play_guess("win_miss", pk(0, 6, 7, 3));
      play_guess("win", pk(6, 0, 7, 3));
      expect_ignored("after_win", pk(1, 1, 1, 1));
      checks++;
      if (win !== 1'b1 || game_over !== 1'b1) begin
         errors++; $display("FAIL win hold: got w=%0b go=%0b expected 1 1", win, game_over);
      end
   endtask

   task automatic test_loss();
      do_start(W'($urandom));
      for (int k = 0; k < MT; k++) begin
         logic [W-1:0] g;
         g = W'($urandom);
         if (g == m_code) g = g ^ W'(1);
         play_guess("loss", g);
      end
      checks++;
      if (turn !== TW'(MT) || win !== 1'b0 || game_over !== 1'b1) begin
         errors++; $display("FAIL loss end: got t=%0d w=%0b go=%0b expected 8 0 1", turn, win, game_over);
      end
      expect_ignored("ninth_guess", m_code);
   endtask

   task automatic test_abort();
      int pulses;
      do_start(pk(1, 2, 3, 4));
      play_guess("pre_abort", pk(0, 0, 0, 0));
      guess_valid = 1'b1;
      guess_in    = pk(1, 2, 3, 4);
      step();
      guess_valid = 1'b0;
      for (int i = 0; i < PEGS + 2; i++) step();
      do_start(pk(7, 7, 0, 1));
      pulses = 0;
      for (int i = 0; i < 2 * LAT; i++) begin step(); if (score_valid) pulses++; end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL abort pulses: got %0d expected 0", pulses); end
      checks++;
      if (turn !== '0 || exact !== '0 || partial !== '0) begin
         errors++; $display("FAIL abort clear: got t=%0d e=%0d p=%0d expected 0 0 0", turn, exact, partial);
      end
      play_guess("post_abort", pk(7, 1, 0, 7));
   endtask

   task automatic test_same_cycle();
      int pulses;
      do_start(pk(2, 2, 2, 2));
      start = 1'b1; code_in = pk(3, 3, 3, 3);
      guess_valid = 1'b1; guess_in = pk(3, 3, 3, 3);
      step();
      start = 1'b0; guess_valid = 1'b0;
      m_code = pk(3, 3, 3, 3);
      pulses = 0;
      for (int i = 0; i < 2 * LAT; i++) begin step(); if (score_valid) pulses++; end
      checks++;
      if (pulses != 0 || turn !== '0 || guess_ready !== 1'b1) begin
         errors++; $display("FAIL same_cycle: got pulses=%0d t=%0d rdy=%0b expected 0 0 1", pulses, turn, guess_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_start(pk(4, 4, 1, 1));
      play_guess("pre_reset", pk(4, 1, 4, 1));
      guess_valid = 1'b1; guess_in = pk(4, 4, 1, 1);
      step();
      guess_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({guess_ready, score_valid, exact, partial, turn, win, game_over} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got rdy=%0b sv=%0b e=%0d p=%0d t=%0d w=%0b go=%0b expected all 0",
                  guess_ready, score_valid, exact, partial, turn, win, game_over);
      end
      for (int i = 0; i < 2 * LAT; i++) begin
         step();
         if (score_valid || guess_ready) begin
            checks++; errors++;
            $display("FAIL reset_mid idle: got sv=%0b rdy=%0b expected 0 0", score_valid, guess_ready);
            break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duplicates();
      test_random();
      test_win();
      test_loss();
      test_abort();
      test_same_cycle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
